// File: rtl/id_branch_predict.sv
// rtl/id_branch_predict.sv - ID-stage branch resolution with a BHT/BTB fetch predictor
module id_branch_predict #(
    parameter int PC_WIDTH   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BHT_DEPTH  = 64,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [PC_WIDTH-1:0]   if_pc,
    output logic                  pred_taken,
    output logic [PC_WIDTH-1:0]   pred_target,

    input  logic                  id_valid,
    input  logic                  id_stall,
    input  logic [PC_WIDTH-1:0]   id_pc,
    input  logic [1:0]            id_type,
    input  logic [2:0]            id_cmp,
    input  logic                  id_pred_taken,
    input  logic [PC_WIDTH-1:0]   id_pred_target,

    input  logic [4:0]            id_rs1,
    input  logic [4:0]            id_rs2,
    input  logic [DATA_WIDTH-1:0] reg_rdata1,
    input  logic [DATA_WIDTH-1:0] reg_rdata2,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  exmem_reg_write,
    input  logic                  memwb_reg_write,
    input  logic [4:0]            exmem_reg_dest,
    input  logic [4:0]            memwb_reg_dest,
    input  logic [DATA_WIDTH-1:0] exmem_reg_wdata,
    input  logic [DATA_WIDTH-1:0] wb_reg_wdata,

    output logic                  flush_pipeline,
    output logic [PC_WIDTH-1:0]   redirect_pc,
    output logic [31:0]           mispredict_cnt
);

    localparam int IDX_W   = $clog2(BHT_DEPTH);
    localparam int TAG_LSB = IDX_W + 2;
    localparam logic [PC_WIDTH-1:0] PC_FOUR = PC_WIDTH'(4);

    localparam logic [1:0] TYPE_BR   = 2'b00;
    localparam logic [1:0] TYPE_JAL  = 2'b01;
    localparam logic [1:0] TYPE_JALR = 2'b10;
    localparam logic [1:0] TYPE_NONE = 2'b11;

    localparam logic [2:0] CMP_EQ  = 3'b000;
    localparam logic [2:0] CMP_NE  = 3'b001;
    localparam logic [2:0] CMP_LT  = 3'b100;
    localparam logic [2:0] CMP_GE  = 3'b101;
    localparam logic [2:0] CMP_LTU = 3'b110;
    localparam logic [2:0] CMP_GEU = 3'b111;

    logic                 tbl_valid  [BHT_DEPTH];
    logic [TAG_WIDTH-1:0] tbl_tag    [BHT_DEPTH];
    logic [PC_WIDTH-1:0]  tbl_target [BHT_DEPTH];
    logic [1:0]           tbl_ctr    [BHT_DEPTH];

    // Fetch-side lookup reads the array directly, so a same-cycle update is not visible.
    logic [IDX_W-1:0]     if_idx;
    logic [TAG_WIDTH-1:0] if_tag;
    logic                 if_hit;

    assign if_idx      = if_pc[IDX_W+1:2];
    assign if_tag      = if_pc[TAG_LSB+TAG_WIDTH-1:TAG_LSB];
    assign if_hit      = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag);
    assign pred_taken  = if_hit && tbl_ctr[if_idx][1];
    assign pred_target = pred_taken ? tbl_target[if_idx] : (if_pc + PC_FOUR);

    logic [DATA_WIDTH-1:0] rs1_fwd;
    logic [DATA_WIDTH-1:0] rs2_fwd;

    always_comb begin
        rs1_fwd = reg_rdata1;
        if (exmem_reg_write && (exmem_reg_dest != 5'd0) && (exmem_reg_dest == id_rs1))
            rs1_fwd = exmem_reg_wdata;
        else if (memwb_reg_write && (memwb_reg_dest != 5'd0) && (memwb_reg_dest == id_rs1))
            rs1_fwd = wb_reg_wdata;
    end

    always_comb begin
        rs2_fwd = reg_rdata2;
        if (exmem_reg_write && (exmem_reg_dest != 5'd0) && (exmem_reg_dest == id_rs2))
            rs2_fwd = exmem_reg_wdata;
        else if (memwb_reg_write && (memwb_reg_dest != 5'd0) && (memwb_reg_dest == id_rs2))
            rs2_fwd = wb_reg_wdata;
    end

    logic br_taken;

    always_comb begin
        br_taken = 1'b0;
        case (id_cmp)
            CMP_EQ:  br_taken = (rs1_fwd == rs2_fwd);
            CMP_NE:  br_taken = (rs1_fwd != rs2_fwd);
            CMP_LT:  br_taken = ($signed(rs1_fwd) <  $signed(rs2_fwd));
            CMP_GE:  br_taken = ($signed(rs1_fwd) >= $signed(rs2_fwd));
            CMP_LTU: br_taken = (rs1_fwd <  rs2_fwd);
            CMP_GEU: br_taken = (rs1_fwd >= rs2_fwd);
            default: br_taken = 1'b0;
        endcase
    end

    logic                actual_taken;
    logic [PC_WIDTH-1:0] target_base;
    logic [PC_WIDTH-1:0] target_sum;
    logic [PC_WIDTH-1:0] actual_target;

    always_comb begin
        actual_taken = 1'b0;
        case (id_type)
            TYPE_BR:   actual_taken = br_taken;
            TYPE_JAL:  actual_taken = 1'b1;
            TYPE_JALR: actual_taken = 1'b1;
            default:   actual_taken = 1'b0;
        endcase
    end

    assign target_base   = (id_type == TYPE_JALR) ? PC_WIDTH'(rs1_fwd) : id_pc;
    assign target_sum    = target_base + PC_WIDTH'(imm);
    assign actual_target = {target_sum[PC_WIDTH-1:1], 1'b0};

    logic resolve;
    logic mispredict;

    assign resolve    = id_valid && !id_stall && (id_type != TYPE_NONE);
    assign mispredict = resolve &&
                        ((actual_taken != id_pred_taken) ||
                         (actual_taken && (id_pred_target != actual_target)));

    assign flush_pipeline = mispredict;
    assign redirect_pc    = !mispredict ? '0 :
                            (actual_taken ? actual_target : (id_pc + PC_FOUR));

    logic [IDX_W-1:0]     id_idx;
    logic [TAG_WIDTH-1:0] id_tag;
    logic                 id_hit;

    assign id_idx = id_pc[IDX_W+1:2];
    assign id_tag = id_pc[TAG_LSB+TAG_WIDTH-1:TAG_LSB];
    assign id_hit = tbl_valid[id_idx] && (tbl_tag[id_idx] == id_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                tbl_valid[i]  <= 1'b0;
                tbl_tag[i]    <= '0;
                tbl_target[i] <= '0;
                tbl_ctr[i]    <= 2'b01;
            end
            mispredict_cnt <= '0;
        end else begin
            if (resolve) begin
                if (id_hit) begin
                    if (actual_taken) begin
                        if (tbl_ctr[id_idx] != 2'b11)
                            tbl_ctr[id_idx] <= tbl_ctr[id_idx] + 2'd1;
                        tbl_target[id_idx] <= actual_target;
                    end else if (tbl_ctr[id_idx] != 2'b00) begin
                        tbl_ctr[id_idx] <= tbl_ctr[id_idx] - 2'd1;
                    end
                end else if (actual_taken) begin
                    // New entries start weakly taken so the next fetch follows them.
                    tbl_valid[id_idx]  <= 1'b1;
                    tbl_tag[id_idx]    <= id_tag;
                    tbl_target[id_idx] <= actual_target;
                    tbl_ctr[id_idx]    <= 2'b10;
                end
            end
            if (mispredict && (mispredict_cnt != 32'hFFFF_FFFF))
                mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_id_branch_predict.sv
// tb/tb_id_branch_predict.sv - directed scoreboard bench for id_branch_predict
module tb_id_branch_predict;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        id_valid, id_stall;
    logic [31:0] id_pc;
    logic [1:0]  id_type;
    logic [2:0]  id_cmp;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;
    logic [4:0]  id_rs1, id_rs2;
    logic [31:0] reg_rdata1, reg_rdata2, imm;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_reg_dest, memwb_reg_dest;
    logic [31:0] exmem_reg_wdata, wb_reg_wdata;
    logic        flush_pipeline;
    logic [31:0] redirect_pc;
    logic [31:0] mispredict_cnt;

    id_branch_predict dut (
        .clk(clk), .rst(rst),
        .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .id_valid(id_valid), .id_stall(id_stall), .id_pc(id_pc), .id_type(id_type),
        .id_cmp(id_cmp), .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .reg_rdata1(reg_rdata1), .reg_rdata2(reg_rdata2),
        .imm(imm), .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
        .exmem_reg_dest(exmem_reg_dest), .memwb_reg_dest(memwb_reg_dest),
        .exmem_reg_wdata(exmem_reg_wdata), .wb_reg_wdata(wb_reg_wdata),
        .flush_pipeline(flush_pipeline), .redirect_pc(redirect_pc),
        .mispredict_cnt(mispredict_cnt)
    );

    always #10 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_t;

    sb_t         sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_cnt = 0;
    logic        pend_flush = 0;

    localparam logic [1:0] BR = 2'b00, JAL = 2'b01, JALR = 2'b10, NONE = 2'b11;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        sb_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        sb_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: got %h expected an entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s: got %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic lookup(input logic [31:0] pc, input logic et, input logic [31:0] etg);
        if_pc = pc;
        sb_push("pred_taken", {31'd0, et});
        sb_push("pred_target", etg);
        #1;
        check({31'd0, pred_taken});
        check(pred_target);
    endtask

    task automatic drive_resolve(input logic st, input logic [1:0] ty, input logic [2:0] cmp,
                                 input logic [31:0] pc, input logic [31:0] im,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 input logic ptk, input logic [31:0] ptg,
                                 input logic ef, input logic [31:0] er);
        id_valid = 1'b1;
        id_stall = st;
        id_type = ty;
        id_cmp = cmp;
        id_pc = pc;
        imm = im;
        reg_rdata1 = r1;
        reg_rdata2 = r2;
        id_pred_taken = ptk;
        id_pred_target = ptg;
        pend_flush = ef;
        sb_push("flush", {31'd0, ef});
        sb_push("redirect", er);
        #1;
        check({31'd0, flush_pipeline});
        check(redirect_pc);
    endtask

    task automatic finish_resolve();
        tick();
        id_valid = 1'b0;
        id_stall = 1'b0;
        id_type = NONE;
        if (pend_flush) exp_cnt++;
        sb_push("mispredict_cnt", exp_cnt);
        #1;
        check(mispredict_cnt);
    endtask

    task automatic clear_fwd();
        exmem_reg_write = 1'b0;
        memwb_reg_write = 1'b0;
        exmem_reg_dest = 5'd0;
        memwb_reg_dest = 5'd0;
        exmem_reg_wdata = 32'd0;
        wb_reg_wdata = 32'd0;
    endtask

    initial begin
        rst = 1'b1;
        if_pc = 32'h0;
        id_valid = 1'b0;
        id_stall = 1'b0;
        id_pc = 32'h0;
        id_type = NONE;
        id_cmp = 3'b000;
        id_pred_taken = 1'b0;
        id_pred_target = 32'h0;
        id_rs1 = 5'd1;
        id_rs2 = 5'd2;
        reg_rdata1 = 32'h0;
        reg_rdata2 = 32'h0;
        imm = 32'h0;
        clear_fwd();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        sb_push("cnt_after_reset", 32'd0);
        sb_push("flush_idle", 32'd0);
        sb_push("redirect_idle", 32'd0);
        #1;
        check(mispredict_cnt);
        check({31'd0, flush_pipeline});
        check(redirect_pc);
        lookup(32'h100, 1'b0, 32'h104);

        // BEQ taken, predicted not-taken; same-cycle lookup must not see the update
        drive_resolve(0, BR, 3'b000, 32'h100, 32'h20, 5, 5, 0, 32'h104, 1, 32'h120);
        lookup(32'h100, 1'b0, 32'h104);
        finish_resolve();
        lookup(32'h100, 1'b1, 32'h120);

        // Counter walks 2 -> 1 -> 0 -> 0, then back up through 1 to 2
        drive_resolve(0, BR, 3'b000, 32'h100, 32'h20, 5, 6, 1, 32'h120, 1, 32'h104);
        finish_resolve();
        lookup(32'h100, 1'b0, 32'h104);
        drive_resolve(0, BR, 3'b000, 32'h100, 32'h20, 5, 6, 0, 32'h104, 0, 32'h0);
        finish_resolve();
        drive_resolve(0, BR, 3'b000, 32'h100, 32'h20, 5, 6, 0, 32'h104, 0, 32'h0);
        finish_resolve();
        drive_resolve(0, BR, 3'b000, 32'h100, 32'h20, 5, 5, 0, 32'h104, 1, 32'h120);
        finish_resolve();
        lookup(32'h100, 1'b0, 32'h104);
        drive_resolve(0, BR, 3'b000, 32'h100, 32'h20, 5, 5, 0, 32'h104, 1, 32'h120);
        finish_resolve();
        lookup(32'h100, 1'b1, 32'h120);

        // Same index, different tag
        lookup(32'h200, 1'b0, 32'h204);

        // JALR forwarding priority
        id_rs1 = 5'd5;
        exmem_reg_write = 1'b1; exmem_reg_dest = 5'd5; exmem_reg_wdata = 32'h2001;
        memwb_reg_write = 1'b1; memwb_reg_dest = 5'd5; wb_reg_wdata = 32'h3000;
        drive_resolve(0, JALR, 3'b000, 32'h204, 32'h2, 32'h1111, 0, 0, 32'h208, 1, 32'h2002);
        finish_resolve();
        exmem_reg_write = 1'b0;
        drive_resolve(0, JALR, 3'b000, 32'h204, 32'h4, 32'h1111, 0, 0, 32'h208, 1, 32'h3004);
        finish_resolve();
        id_rs1 = 5'd0;
        exmem_reg_write = 1'b1; exmem_reg_dest = 5'd0; exmem_reg_wdata = 32'h5000;
        memwb_reg_dest = 5'd0; wb_reg_wdata = 32'h6000;
        drive_resolve(0, JALR, 3'b000, 32'h204, 32'h40, 32'h0, 0, 1, 32'h40, 0, 32'h0);
        finish_resolve();
        clear_fwd();
        id_rs1 = 5'd1;

        // JAL: correct prediction, then wrong target with an odd offset
        drive_resolve(0, JAL, 3'b000, 32'h308, 32'h10, 0, 0, 1, 32'h318, 0, 32'h0);
        finish_resolve();
        lookup(32'h308, 1'b1, 32'h318);
        drive_resolve(0, JAL, 3'b000, 32'h308, 32'h11, 0, 0, 1, 32'h31C, 1, 32'h318);
        finish_resolve();

        // Signed vs unsigned compares, NE, undefined code
        drive_resolve(0, BR, 3'b100, 32'h40C, 32'h8, 32'hFFFF_FFFF, 1, 0, 32'h410, 1, 32'h414);
        finish_resolve();
        drive_resolve(0, BR, 3'b101, 32'h40C, 32'h8, 32'hFFFF_FFFF, 1, 0, 32'h410, 0, 32'h0);
        finish_resolve();
        drive_resolve(0, BR, 3'b110, 32'h40C, 32'h8, 32'hFFFF_FFFF, 1, 1, 32'h414, 1, 32'h410);
        finish_resolve();
        drive_resolve(0, BR, 3'b111, 32'h40C, 32'h8, 32'hFFFF_FFFF, 1, 1, 32'h414, 0, 32'h0);
        finish_resolve();
        drive_resolve(0, BR, 3'b001, 32'h40C, 32'h8, 5, 5, 0, 32'h410, 0, 32'h0);
        finish_resolve();
        drive_resolve(0, BR, 3'b010, 32'h40C, 32'h8, 5, 6, 0, 32'h410, 0, 32'h0);
        finish_resolve();

        // Stalled mispredict: no flush, no update
        drive_resolve(1, BR, 3'b000, 32'h510, 32'h20, 5, 5, 0, 32'h514, 0, 32'h0);
        finish_resolve();
        lookup(32'h510, 1'b0, 32'h514);

        // Reset coincident with a resolving mispredict
        rst = 1'b1;
        drive_resolve(0, BR, 3'b000, 32'h614, 32'h20, 5, 5, 0, 32'h618, 1, 32'h634);
        tick();
        rst = 1'b0;
        id_valid = 1'b0;
        id_type = NONE;
        exp_cnt = 0;
        sb_push("cnt_after_rst_collide", exp_cnt);
        #1;
        check(mispredict_cnt);
        lookup(32'h614, 1'b0, 32'h618);
        lookup(32'h100, 1'b0, 32'h104);
        lookup(32'h308, 1'b0, 32'h30C);

        if (sb.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_branch_predict.md
ID_BRANCH_PREDICT -- requirements
Module: id_branch_predict

Interface
REQ-001 Parameters (name, default, meaning): PC_WIDTH, 32, program-counter width; DATA_WIDTH, 32, register data width; BHT_DEPTH, 64, predictor entries (power of two, 4..1024); TAG_WIDTH, 8, BTB tag bits.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-003 The IF lookup port SHALL be: if_pc input PC_WIDTH, fetch PC; pred_taken output 1, predict taken; pred_target output PC_WIDTH, predicted target.
REQ-004 The ID resolve port SHALL be: id_valid input 1, branch/jump present in ID; id_stall input 1, ID held; id_pc input PC_WIDTH; id_type input 2, 00 branch / 01 JAL / 10 JALR / 11 none; id_cmp input 3, 000 EQ / 001 NE / 100 LT / 101 GE / 110 LTU / 111 GEU; id_pred_taken input 1 and id_pred_target input PC_WIDTH, prediction carried from IF.
REQ-005 The operand port SHALL be: id_rs1, id_rs2 input 5 each; reg_rdata1, reg_rdata2, imm input DATA_WIDTH each; exmem_reg_write, memwb_reg_write input 1 each; exmem_reg_dest, memwb_reg_dest input 5 each; exmem_reg_wdata, wb_reg_wdata input DATA_WIDTH each.
REQ-006 The outputs SHALL be: flush_pipeline output 1; redirect_pc output PC_WIDTH; mispredict_cnt output 32, saturating statistics counter.

Function
REQ-007 Index = pc[log2(BHT_DEPTH)+1:2]; tag = the next TAG_WIDTH bits above the index.
REQ-008 Each entry SHALL hold: valid, tag, target (PC_WIDTH), and a 2-bit saturating counter.
REQ-009 Lookup SHALL be combinational: pred_taken = valid & tag match & counter[1]; pred_target = stored target when pred_taken, else if_pc+4.
REQ-010 Forwarding per source: EX/MEM write (dest != x0, dest == rs) wins over MEM/WB write (dest != x0, dest == rs), which wins over the register file value.
REQ-011 Actual outcome: branch taken per id_cmp on forwarded rs1/rs2 (LT/GE signed, LTU/GEU unsigned); JAL/JALR always taken; undefined id_cmp codes are not-taken.
REQ-012 Actual target: branch/JAL = (id_pc+imm) & ~1; JALR = (rs1_fwd+imm) & ~1; all arithmetic is modulo 2^PC_WIDTH.
REQ-013 Resolution SHALL occur when id_valid=1, id_stall=0, and id_type!=11.
REQ-014 Mispredict = (actual_taken != id_pred_taken) OR (actual_taken AND id_pred_target != actual target).
REQ-015 On mispredict, flush_pipeline SHALL be 1 in the same cycle (combinational); redirect_pc = actual target if taken, else id_pc+4. Otherwise flush_pipeline=0 and redirect_pc=0.
REQ-016 Update at the clock edge after resolution:
- On hit: counter +1 if taken (saturates at 3), -1 if not taken (saturates at 0); target rewritten if taken.
- On miss and taken: allocate the entry (valid=1, tag, target, counter=2).
- On miss and not taken: no change.
REQ-017 When id_stall=1, flush_pipeline=0 and no table or counter update SHALL occur.
REQ-018 A same-cycle lookup and update to the same index SHALL return the pre-update contents (no bypass).
REQ-019 mispredict_cnt SHALL increment by 1 on each resolved mispredict and hold at 0xFFFFFFFF.

Reset
REQ-020 While rst=1 at a clock edge, all valid bits clear, all counters become 01, all targets and tags become 0, and mispredict_cnt becomes 0.
REQ-021 rst SHALL override a simultaneous update; combinational outputs keep following their inputs during reset.

Verification
REQ-022 After reset, if_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-023 Branch BEQ at id_pc=0x100, imm=0x20, rs1=rs2=5, pred_taken=0 -> flush=1, redirect_pc=0x120, mispredict_cnt=1. Next cycle lookup 0x100 -> pred_taken=1, pred_target=0x120.
REQ-024 Entry at counter 2: two not-taken resolves -> counter 0, flush on the first (predicted taken), redirect_pc=0x104. A third not-taken holds at 0.
REQ-025 JALR with rs1 in EX/MEM (dest=x5, wdata=0x2001), MEM/WB also writing x5=0x3000, imm=2 -> target 0x2002, EX/MEM value used.
REQ-026 Mispredicting branch with id_stall=1 -> flush=0, table and counter unchanged. Aliasing PC (same index, different tag) -> miss, pred_taken=0.
REQ-027 Reset asserted in the same cycle as a resolving mispredict -> after the edge, the table is cleared and mispredict_cnt=0.
